ssriscv_dec_exe_mem: RTL and testbench

Single-cycle decode/execute/memory slice of the ssriscv RV32I core. Decodes the current instruction, selects ALU operands, computes the ALU result and branch condition, and performs data-memory loads and stores. It sits between the PC/instruction-memory/register-file logic and the next-PC logic. Everything is combinational except store writes and the sticky error flag.

---
 rtl/ssriscv_pkg.sv | 41 ++++
 rtl/ssriscv_dmem_core.sv | 66 ++++++
 rtl/ssriscv_dec_exe_mem.sv | 162 ++++++++++++++++
 tb/tb_ssriscv_dec_exe_mem.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ssriscv_pkg.sv
// Shared constants for the ssriscv RV32I core: opcodes, ALU ops,
// load/store widths and branch conditions.
package ssriscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [2:0] ST_B = 3'b000;
  localparam logic [2:0] ST_H = 3'b001;
  localparam logic [2:0] ST_W = 3'b010;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/ssriscv_dmem_core.sv
// Byte-enabled word memory: little-endian byte/half/word stores and
// load extraction with sign or zero extension. Contents are not reset.
module ssriscv_dmem_core
  import ssriscv_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [1:0]    boff,
  input  logic [2:0]    f3,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // byte enables and lane-replicated write data from store width/offset
  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    case (f3)
      ST_B: begin
        be    = 4'b0001 << boff;
        wlane = {4{wdata[7:0]}};
      end
      ST_H: begin
        be    = boff[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      ST_W: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // write only the enabled byte lanes
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we && be[b]) mem[widx][b*8 +: 8] <= wlane[b*8 +: 8];
  end

  assign word   = mem[widx];
  assign byte_v = word[{boff, 3'b000} +: 8];
  assign half_v = boff[1] ? word[31:16] : word[15:0];

  // load extraction and extension
  always_comb begin
    rdata = 32'h0;
    case (f3)
      LD_B:  rdata = {{24{byte_v[7]}}, byte_v};
      LD_H:  rdata = {{16{half_v[15]}}, half_v};
      LD_W:  rdata = word;
      LD_BU: rdata = {24'h0, byte_v};
      LD_HU: rdata = {16'h0, half_v};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/ssriscv_dec_exe_mem.sv
// Single-cycle decode/execute/memory slice of the ssriscv RV32I core.
// Optional: define SSRISCV_MISALIGN_CHECK_EN to flag misaligned lh/lhu/sh
// and lw/sw as illegal.
module ssriscv_dec_exe_mem
  import ssriscv_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        is_bxx,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        take_branch,
  output logic        reg_write,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        error
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_op, is_opimm, is_load, is_store, is_lui, is_auipc;
  logic        opc_ok, f3_bad, misalign;
  logic [31:0] in1, in2, alu_res, mem_addr, ld_data;
  logic [2:0]  alu_op;
  logic        arith, br_cond;
  logic [4:0]  shamt;
  logic        unused_addr_hi;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  assign is_op    = (opc == OPC_OP);
  assign is_opimm = (opc == OPC_OPIMM);
  assign is_load  = (opc == OPC_LOAD);
  assign is_store = (opc == OPC_STORE);
  assign is_bxx   = (opc == OPC_BRANCH);
  assign is_jal   = (opc == OPC_JAL);
  assign is_jalr  = (opc == OPC_JALR);
  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);

  assign opc_ok = is_op | is_opimm | is_load | is_store | is_bxx |
                  is_jal | is_jalr | is_lui | is_auipc;

  // immediate by format, sign-extended
  always_comb begin
    imm = 32'h0;
    if (is_opimm || is_load || is_jalr)
      imm = {{20{instr[31]}}, instr[31:20]};
    else if (is_store)
      imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (is_bxx)
      imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (is_lui || is_auipc)
      imm = {instr[31:12], 12'h000};
    else if (is_jal)
      imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  assign mem_addr       = rs1_data + imm;
  assign unused_addr_hi = ^mem_addr[31:AW+2];

`ifdef SSRISCV_MISALIGN_CHECK_EN
  // halfword needs addr[0]=0, word needs addr[1:0]=0
  assign misalign = (is_load || is_store) &&
                    (((f3[1:0] == 2'b01) && mem_addr[0]) ||
                     ((f3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // funct3 encodings that are reserved within a legal opcode
  always_comb begin
    f3_bad = 1'b0;
    if (is_bxx)   f3_bad = (f3 == 3'b010) || (f3 == 3'b011);
    if (is_load)  f3_bad = !(f3 inside {LD_B, LD_H, LD_W, LD_BU, LD_HU});
    if (is_store) f3_bad = !(f3 inside {ST_B, ST_H, ST_W});
  end

  assign illegal = !opc_ok || f3_bad || misalign;

  // operand and ALU op selection
  always_comb begin
    in1 = rs1_data;
    if (is_auipc || is_jal || is_jalr) in1 = pc;
    else if (is_lui)                   in1 = 32'h0;
    in2 = rs2_data;
    if (is_jal || is_jalr)                                         in2 = 32'd4;
    else if (is_opimm || is_load || is_store || is_lui || is_auipc) in2 = imm;
    alu_op = (is_op || is_opimm) ? f3 : ALU_ADD;
    arith  = is_op ? instr[30] : (is_opimm && f3 == ALU_SR) ? instr[30] : 1'b0;
  end

  assign shamt = in2[4:0];

  // ALU
  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      ALU_ADD:  alu_res = arith ? in1 - in2 : in1 + in2;
      ALU_SLL:  alu_res = in1 << shamt;
      ALU_SLT:  alu_res = {31'h0, $signed(in1) < $signed(in2)};
      ALU_SLTU: alu_res = {31'h0, in1 < in2};
      ALU_XOR:  alu_res = in1 ^ in2;
      ALU_SR:   alu_res = arith ? 32'($signed(in1) >>> shamt) : in1 >> shamt;
      ALU_OR:   alu_res = in1 | in2;
      ALU_AND:  alu_res = in1 & in2;
      default:  alu_res = 32'h0;
    endcase
  end

  // branch condition on register operands
  always_comb begin
    br_cond = 1'b0;
    case (f3)
      BR_EQ:  br_cond = rs1_data == rs2_data;
      BR_NE:  br_cond = rs1_data != rs2_data;
      BR_LT:  br_cond = $signed(rs1_data) <  $signed(rs2_data);
      BR_GE:  br_cond = $signed(rs1_data) >= $signed(rs2_data);
      BR_LTU: br_cond = rs1_data <  rs2_data;
      BR_GEU: br_cond = rs1_data >= rs2_data;
      default: br_cond = 1'b0;
    endcase
  end

  assign take_branch = is_bxx && !illegal && br_cond;
  assign reg_write   = !illegal && (is_op || is_opimm || is_load || is_jal ||
                                    is_jalr || is_lui || is_auipc);
  assign wb_data     = is_load ? ld_data : alu_res;

  ssriscv_dmem_core #(.MEM_WORDS(MEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (is_store && !illegal && !rst),
    .widx  (mem_addr[AW+1:2]),
    .boff  (mem_addr[1:0]),
    .f3    (f3),
    .wdata (rs2_data),
    .rdata (ld_data)
  );

  // sticky illegal-instruction flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          error <= 1'b0;
    else if (illegal) error <= 1'b1;
  end

endmodule

// File: tb/tb_ssriscv_dec_exe_mem.sv
// Directed-vector bench for ssriscv_dec_exe_mem.
module tb_ssriscv_dec_exe_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0000_0013;
  logic [31:0] pc = 32'h0;
  logic [31:0] rs1_data = 32'h0, rs2_data = 32'h0;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, wb_data;
  logic        is_bxx, is_jal, is_jalr, take_branch, reg_write, illegal, error;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ssriscv_dec_exe_mem #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .is_bxx(is_bxx), .is_jal(is_jal), .is_jalr(is_jalr),
    .take_branch(take_branch), .reg_write(reg_write), .wb_data(wb_data),
    .illegal(illegal), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f,
                                        input logic [4:0] d, input logic [6:0] op);
    return {f7, r2, r1, f, d, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                        input logic [2:0] f, input logic [4:0] d,
                                        input logic [6:0] op);
    return {im, r1, f, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f);
    return {im[11:5], r2, r1, f, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f);
    return {im[12], im[10:5], r2, r1, f, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
  endfunction

  // present one instruction mid-cycle; it is held across the next rising edge
  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr = i; rs1_data = a; rs2_data = b;
    #1;
  endtask

  initial begin
    #2;
    chk("reset_error", {31'h0, error}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // OP sub x3,x1,x2
    drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'd5, 32'd7);
    chk("sub_wb", wb_data, 32'hFFFF_FFFE);
    chk("sub_rw", {31'h0, reg_write}, 32'h1);
    chk("fields", {17'h0, rs1, rs2, rd}, {17'h0, 5'd1, 5'd2, 5'd3});
    chk("op_imm0", imm, 32'h0);

    // shifts right by 4
    drive(enc_i(12'h404, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'h8000_0000, 32'h0);
    chk("srai", wb_data, 32'hF800_0000);
    drive(enc_i(12'h004, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'h8000_0000, 32'h0);
    chk("srli", wb_data, 32'h0800_0000);
    // addi with instr[30] set must still add
    drive(enc_i(12'h400, 5'd1, 3'b000, 5'd4, 7'b0010011), 32'd1, 32'h0);
    chk("addi_b30", wb_data, 32'h0000_0401);
    drive(enc_i(12'hFFF, 5'd0, 3'b000, 5'd4, 7'b0010011), 32'd0, 32'h0);
    chk("addi_neg", wb_data, 32'hFFFF_FFFF);
    // slt signed vs sltu
    drive(enc_r(7'b0, 5'd2, 5'd1, 3'b010, 5'd5, 7'b0110011), 32'hFFFF_FFFF, 32'd1);
    chk("slt", wb_data, 32'h1);
    drive(enc_r(7'b0, 5'd2, 5'd1, 3'b011, 5'd5, 7'b0110011), 32'hFFFF_FFFF, 32'd1);
    chk("sltu", wb_data, 32'h0);

    // branches
    drive(enc_b(13'h0008, 5'd2, 5'd1, 3'b100), 32'hFFFF_FFFF, 32'd1);
    chk("blt_take", {31'h0, take_branch}, 32'h1);
    chk("blt_bxx", {31'h0, is_bxx}, 32'h1);
    chk("b_imm", imm, 32'h8);
    chk("b_rw", {31'h0, reg_write}, 32'h0);
    drive(enc_b(13'h1FFC, 5'd2, 5'd1, 3'b110), 32'hFFFF_FFFF, 32'd1);
    chk("bltu_take", {31'h0, take_branch}, 32'h0);
    chk("b_imm_neg", imm, 32'hFFFF_FFFC);

    // stores commit at the rising edge inside drive's hold window
    drive(enc_s(12'd8, 5'd2, 5'd1, 3'b010), 32'd0, 32'h1122_3344);
    chk("sw_rw", {31'h0, reg_write}, 32'h0);
    chk("s_imm", imm, 32'h8);
    drive(enc_s(12'd9, 5'd2, 5'd1, 3'b000), 32'd0, 32'h0000_00AA);
    drive(enc_i(12'd8, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'd0, 32'h0);
    chk("lw8", wb_data, 32'h1122_AA44);
    chk("lw_rw", {31'h0, reg_write}, 32'h1);
    drive(enc_i(12'd9, 5'd1, 3'b000, 5'd6, 7'b0000011), 32'd0, 32'h0);
    chk("lb9", wb_data, 32'hFFFF_FFAA);
    drive(enc_i(12'd9, 5'd1, 3'b100, 5'd6, 7'b0000011), 32'd0, 32'h0);
    chk("lbu9", wb_data, 32'h0000_00AA);
    drive(enc_i(12'd10, 5'd1, 3'b001, 5'd6, 7'b0000011), 32'd0, 32'h0);
    chk("lh10", wb_data, 32'h0000_1122);
    // address wraps at 4 KiB
    drive(enc_i(12'd8, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'h0000_1000, 32'h0);
    chk("lw_wrap", wb_data, 32'h1122_AA44);
`ifndef SSRISCV_MISALIGN_CHECK_EN
    drive(enc_i(12'd10, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'd0, 32'h0);
    chk("lw_mis_ok", wb_data, 32'h1122_AA44);
    chk("lw_mis_leg", {31'h0, illegal}, 32'h0);
`endif

    // store under reset is dropped
    @(negedge clk); rst = 1'b1;
    instr = enc_s(12'd8, 5'd2, 5'd1, 3'b010); rs1_data = 0; rs2_data = 32'hDEAD_BEEF;
    @(negedge clk); rst = 1'b0;
    instr = enc_i(12'd8, 5'd1, 3'b010, 5'd6, 7'b0000011);
    #1;
    chk("rst_nostore", wb_data, 32'h1122_AA44);

    // jumps and upper immediates
    pc = 32'h100;
    drive(enc_j(21'h10, 5'd1), 32'h0, 32'h0);
    chk("jal_wb", wb_data, 32'h104);
    chk("jal_flag", {31'h0, is_jal}, 32'h1);
    chk("jal_imm", imm, 32'h10);
    drive(enc_i(12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111), 32'h0, 32'h0);
    chk("jalr_wb", wb_data, 32'h104);
    drive({20'h12345, 5'd7, 7'b0110111}, 32'hFFFF_FFFF, 32'h0);
    chk("lui", wb_data, 32'h1234_5000);
    drive({20'h00001, 5'd7, 7'b0010111}, 32'h0, 32'h0);
    chk("auipc", wb_data, 32'h0000_1100);
    chk("err_clean", {31'h0, error}, 32'h0);

    // illegal opcode and the sticky flag
    drive(32'hFFFF_FFFF, 32'h0, 32'h0);
    chk("ill", {31'h0, illegal}, 32'h1);
    chk("ill_rw", {31'h0, reg_write}, 32'h0);
    chk("ill_err_pre", {31'h0, error}, 32'h0);
    drive(enc_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h0, 32'h0);
    chk("err_set", {31'h0, error}, 32'h1);
    chk("nop_leg", {31'h0, illegal}, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("err_async_clr", {31'h0, error}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // reserved branch funct3 with equal operands
    drive(enc_b(13'h0008, 5'd2, 5'd1, 3'b010), 32'd3, 32'd3);
    chk("br010_ill", {31'h0, illegal}, 32'h1);
    chk("br010_take", {31'h0, take_branch}, 32'h0);
`ifdef SSRISCV_MISALIGN_CHECK_EN
    drive(enc_i(12'd2, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'd0, 32'h0);
    chk("lw_mis_ill", {31'h0, illegal}, 32'h1);
    // misaligned sw must not write
    drive(enc_s(12'd10, 5'd2, 5'd1, 3'b010), 32'd0, 32'h5555_5555);
    chk("sw_mis_ill", {31'h0, illegal}, 32'h1);
    drive(enc_i(12'd8, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'd0, 32'h0);
    chk("sw_mis_nowr", wb_data, 32'h1122_AA44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
